present_encryptor_hs: RTL
=========================

Name: present_encryptor_hs

Overview:
Iterative PRESENT block-cipher encryptor, one round per clock, with a selectable key size (80 or 128 bit). It has valid/ready handshakes on the input and output sides and a round-counter-driven FSM. It is the parametrised successor of the existing load-pulse PRESENT-80 core and sits between a plaintext source and a ciphertext sink that may stall. The master key stays in a dedicated register, so back-to-back blocks under one key need no reload.

Parameters:
KEY_WIDTH, 80, master key width; legal values are 80 and 128 only (elaboration error otherwise).
ROUNDS, 31, number of round functions applied; the final whitening uses round key ROUNDS+1.

Ports:
clk_i  in  1  clock, rising-edge.
rst_i  in  1  asynchronous, active-high reset.
key_i  in  KEY_WIDTH  master key.
key_load_i  in  1  strobe: capture key_i into the master key register.
data_i  in  64  plaintext.
data_valid_i  in  1  plaintext valid.
data_ready_o  out  1  block can accept plaintext.
data_o  out  64  ciphertext, registered.
data_valid_o  out  1  ciphertext valid.
out_ready_i  in  1  sink accepts ciphertext.
busy_o  out  1  high in RUN.

Behaviour:
- Reset (asynchronous, rst_i high):
  - FSM goes to IDLE.
  - Master key, working key, state register, round counter and data_o all clear to 0.
  - data_valid_o=0, busy_o=0.
  - data_ready_o=1 once in IDLE (decoded from the FSM).
- Reset mid-RUN or mid-DONE aborts the block and discards its result. The key is lost, so the key must be reloaded.
- FSM states:
  - IDLE: data_ready_o=1. When data_valid_i&&data_ready_o: state_reg<=data_i, wkey<=master key (or key_i if key_load_i is high in the same cycle), rcnt<=1, go to RUN.
  - RUN: busy_o=1 and data_ready_o=0. Each cycle:
    - state_reg <= P(S(state_reg ^ wkey[KEY_WIDTH-1 -: 64]))
    - wkey <= update(wkey, rcnt)
    - rcnt++
  - RUN exit: in the cycle where rcnt==ROUNDS, data_o <= next_state ^ next_wkey[top 64] and the FSM goes to DONE.
  - DONE: data_valid_o=1 and data_o is held stable. When out_ready_i=1, go to IDLE and drop data_valid_o on that edge.
- Latency: plaintext accepted at edge N gives data_valid_o=1 after edge N+ROUNDS (31 cycles).
- Throughput: one block per ROUNDS+2 cycles with no stall. data_ready_o is low in DONE, so there is no overlap between blocks.
- Key schedule, 80-bit:
  - Rotate left 61.
  - S-box on bits [79:76].
  - bits[19:15] ^= rcnt[4:0].
- Key schedule, 128-bit:
  - Rotate left 61.
  - S-box on bits [127:124] and [123:120].
  - bits[66:62] ^= rcnt[4:0].
- S-box is the PRESENT 4-bit table C56B90AD3EF84712. P-layer moves bit i to (16*i) mod 63, and bit 63 stays at 63.
- rcnt is 5 bits wide and never wraps within a block.
- key_load_i handling:
  - Honoured only in IDLE.
  - Ignored in RUN and DONE, so the current block is unaffected.
  - If it coincides with a data accept, the new key is both stored and used for that block.
- data_valid_i while not ready: no effect. The source must hold its data.
- out_ready_i stalls in DONE: unbounded wait, with data_o and data_valid_o stable throughout.

Test Plan:
- KEY_WIDTH=80 vectors: key 0, pt 0 -> 5579C1387B228445; key FFFF…FF, pt 0 -> E72C46C0F5945049; key 0, pt FF…FF -> A112FFC72F68417B; key FF…FF, pt FF…FF -> 3333DCD3213210D2. Check data_valid_o exactly 31 cycles after accept.
- KEY_WIDTH=128 vectors: key 0, pt 0 -> 96DB702A2E6900AF; key FF…FF, pt FF…FF -> 628D9FBD4218E5B4.
- Back-to-back blocks under one key load, with out_ready_i held low for 10 cycles in DONE: data_o stable, data_ready_o=0 throughout, second block accepted the cycle after the handshake completes.
- key_load_i pulsed mid-RUN with a different key: current ciphertext is unchanged (still 5579C1387B228445). The next block uses the new key.
- key_load_i and data_valid_i in the same IDLE cycle with key FF…FF, pt 0 -> E72C46C0F5945049.
- rst_i asserted at round 15: outputs go to 0 immediately, FSM is IDLE. Reload key 0 and pt 0 -> 5579C1387B228445.

Source files
------------

// File: rtl/present_encryptor_hs.sv
// present_encryptor_hs
// Iterative PRESENT block-cipher encryptor. Each clock applies one round, and
// the key size (80 or 128 bit) is chosen at elaboration. The input and output
// sides both use valid/ready handshakes. The master key sits in its own
// register, so consecutive blocks under one key need no reload.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   key_i         master key (KEY_WIDTH bits)
//   key_load_i    capture key_i into the master key register (IDLE only)
//   data_i        64-bit plaintext
//   data_valid_i  plaintext valid
//   data_ready_o  block can accept plaintext (high in IDLE)
//   data_o        registered 64-bit ciphertext
//   data_valid_o  ciphertext valid (high in DONE)
//   out_ready_i   sink accepts ciphertext
//   busy_o        high while rounds are being computed
module present_encryptor_hs #(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 key_load_i,
  input  logic [63:0]          data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [63:0]          data_o,
  output logic                 data_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  // Only the two key sizes defined by PRESENT have a key schedule here.
  generate
    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
      $error("present_encryptor_hs: KEY_WIDTH must be 80 or 128");
    end
  endgenerate

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               fsm;
  logic [KEY_WIDTH-1:0] master_key;
  logic [KEY_WIDTH-1:0] wkey;
  logic [KEY_WIDTH-1:0] wkey_next;
  logic [63:0]          state_reg;
  logic [63:0]          round_out;
  logic [4:0]           rcnt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit 63 maps onto itself, and every other bit i moves to (16*i) mod 63.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Key schedule step: rotate left by 61, S-box the top nibble (two nibbles
  // for 128-bit keys), then XOR the round counter into the fixed bit window.
  function automatic logic [KEY_WIDTH-1:0] key_update(input logic [KEY_WIDTH-1:0] k,
                                                      input logic [4:0] rc);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = sbox(r[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) begin
      r[KEY_WIDTH-5 -: 4] = sbox(r[KEY_WIDTH-5 -: 4]);
      r[66:62] = r[66:62] ^ rc;
    end else begin
      r[19:15] = r[19:15] ^ rc;
    end
    return r;
  endfunction

  // One cipher round and the matching key-schedule step. On the final round,
  // the output whitening uses the updated key, so wkey_next feeds data_o too.
  always_comb begin
    round_out = p_layer(s_layer(state_reg ^ wkey[KEY_WIDTH-1 -: 64]));
    wkey_next = key_update(wkey, rcnt);
  end

  // data_ready_o is decoded straight from the FSM, so it is high as soon as
  // reset puts the block in IDLE.
  assign data_ready_o = (fsm == IDLE);

  // Control FSM and datapath registers. A key load presented in the accept
  // cycle is stored and also used for that block. Outside IDLE, key loads are
  // ignored so the running block is never disturbed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm          <= IDLE;
      master_key   <= '0;
      wkey         <= '0;
      state_reg    <= '0;
      rcnt         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (key_load_i) begin
            master_key <= key_i;
          end
          if (data_valid_i) begin
            state_reg <= data_i;
            wkey      <= key_load_i ? key_i : master_key;
            rcnt      <= 5'd1;
            busy_o    <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          state_reg <= round_out;
          wkey      <= wkey_next;
          if (rcnt == LAST_ROUND) begin
            data_o       <= round_out ^ wkey_next[KEY_WIDTH-1 -: 64];
            data_valid_o <= 1'b1;
            busy_o       <= 1'b0;
            fsm          <= DONE;
          end else begin
            rcnt <= rcnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            data_valid_o <= 1'b0;
            fsm          <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule
